// File: rtl/sram_frame_reader_pkg.sv
// Shared constants for the frame reader: SRAM geometry, frame bases and FSM encodings.
// The frame-base constants are shared with the image buffer writer.
package sram_frame_reader_pkg;

    localparam int ADDR_WIDTH   = 18;
    localparam int PIX_PER_WORD = 4;
    localparam int CNT_WIDTH    = 19;

    localparam logic [ADDR_WIDTH-1:0] FRAME0_BASE_DEF = 18'd0;
    localparam logic [ADDR_WIDTH-1:0] FRAME1_BASE_DEF = 18'd120000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [ADDR_WIDTH-1:0] frame_base(
        input logic                  sel,
        input logic [ADDR_WIDTH-1:0] frame1_base
    );
        if (sel) begin
            return frame1_base;
        end else begin
            return FRAME0_BASE_DEF;
        end
    endfunction

endpackage

// File: rtl/sram_frame_reader_if.sv
// Handshake bundle of the frame reader: start/done pair, arbiter R1 read port and pixel stream.
interface sram_frame_reader_if;
    import sram_frame_reader_pkg::*;

    logic                  start;
    logic                  start_ack;
    logic                  frame_sel;
    logic                  done;
    logic                  done_ack;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_valid;
    logic                  addr_ready;
    logic [31:0]           data;
    logic                  data_valid;
    logic                  data_ready;
    logic [7:0]            pixel;
    logic                  pixel_valid;
    logic                  pixel_ready;
    logic                  pixel_last;

    modport master (
        input  start, frame_sel, done_ack, addr_ready, data, data_valid, pixel_ready,
        output start_ack, done, addr, addr_valid, data_ready, pixel, pixel_valid, pixel_last
    );

    modport slave (
        output start, frame_sel, done_ack, addr_ready, data, data_valid, pixel_ready,
        input  start_ack, done, addr, addr_valid, data_ready, pixel, pixel_valid, pixel_last
    );

endinterface

// File: rtl/sram_frame_reader_sync_word_fifo.sv
// Synchronous first-word-fall-through word FIFO with occupancy count.
module sync_word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset_l,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign push_ok_s = push && (count_r != CW'(DEPTH));
    assign pop_ok_s  = pop && (count_r != {CW{1'b0}});
    assign rd_data   = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign empty     = (count_r == {CW{1'b0}});

    // Storage array, cleared on reset so no stale word is ever visible.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_ok_s && !push_ok_s) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: rtl/sram_frame_reader.sv
// Streams one stored 8-bit grayscale frame out of ZBT SRAM as a raster-order pixel stream,
// issuing credit-limited word reads on arbiter port R1 and unpacking 4 pixels per word.
module sram_frame_reader
    import sram_frame_reader_pkg::*;
#(
    parameter int N_PIXEL     = 480000,
    parameter int FRAME1_BASE = 120000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                clock,
    input  logic                reset_l,
    sram_frame_reader_if.master bus
);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int WORDS = N_PIXEL / PIX_PER_WORD;

    localparam logic [CNT_WIDTH-1:0]  WORDS_C    = CNT_WIDTH'(WORDS);
    localparam logic [CNT_WIDTH-1:0]  LAST_PIX_C = CNT_WIDTH'(N_PIXEL - 1);
    localparam logic [ADDR_WIDTH-1:0] F1_BASE_C  = ADDR_WIDTH'(FRAME1_BASE);

    logic [1:0]            state_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic                  start_ack_r;
    logic                  done_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  addr_valid_r;
    logic                  data_ready_r;
    logic [CNT_WIDTH-1:0]  word_cnt_r;
    logic [CNT_WIDTH-1:0]  pix_cnt_r;
    logic                  last_r;
    logic [CW-1:0]         outst_r;
    logic [31:0]           shift_r;
    logic [1:0]            byte_idx_r;
    logic                  unpack_full_r;

    logic                  start_go_s;
    logic                  run_s;
    logic                  addr_fire_s;
    logic                  data_fire_s;
    logic                  run_data_s;
    logic                  pixel_fire_s;
    logic                  last_fire_s;
    logic                  unpack_need_s;
    logic                  pop_s;
    logic                  bypass_s;
    logic                  push_s;
    logic                  load_s;
    logic [31:0]           load_word_s;
    logic [31:0]           fifo_rd_s;
    logic [CW-1:0]         fifo_count_s;
    logic                  fifo_empty_s;
    logic [CW:0]           fifo_cnt_next_s;
    logic [CW:0]           outst_next_s;
    logic [CW+1:0]         in_flight_next_s;
    logic [CNT_WIDTH-1:0]  word_cnt_next_s;
    logic [CNT_WIDTH-1:0]  addr_sum_s;

    assign start_go_s   = (state_r == ST_IDLE) && bus.start;
    assign run_s        = (state_r == ST_RUN);
    assign addr_fire_s  = addr_valid_r && bus.addr_ready;
    assign data_fire_s  = bus.data_valid && data_ready_r;
    assign run_data_s   = data_fire_s && run_s;
    assign pixel_fire_s = unpack_full_r && bus.pixel_ready;
    assign last_fire_s  = pixel_fire_s && last_r;

    // The unpack register takes a new word when empty or while its last byte is leaving.
    assign unpack_need_s = !unpack_full_r || (pixel_fire_s && (byte_idx_r == 2'd3));
    assign pop_s         = run_s && unpack_need_s && !fifo_empty_s;
    assign bypass_s      = run_data_s && unpack_need_s && fifo_empty_s;
    assign push_s        = run_data_s && !bypass_s;
    assign load_s        = pop_s || bypass_s;
    assign load_word_s   = pop_s ? fifo_rd_s : bus.data;

    sync_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock   (clock),
        .reset_l (reset_l),
        .push    (push_s),
        .wr_data (bus.data),
        .pop     (pop_s),
        .rd_data (fifo_rd_s),
        .count   (fifo_count_s),
        .empty   (fifo_empty_s)
    );

    // Next-cycle occupancy figures used to register addr_valid and data_ready.
    always_comb begin
        fifo_cnt_next_s = {1'b0, fifo_count_s};
        outst_next_s    = {1'b0, outst_r};
        word_cnt_next_s = word_cnt_r;
        if (push_s && !pop_s) begin
            fifo_cnt_next_s = {1'b0, fifo_count_s} + (CW+1)'(1);
        end else if (pop_s && !push_s) begin
            fifo_cnt_next_s = {1'b0, fifo_count_s} - (CW+1)'(1);
        end else begin
            fifo_cnt_next_s = {1'b0, fifo_count_s};
        end
        if (addr_fire_s && !run_data_s) begin
            outst_next_s = {1'b0, outst_r} + (CW+1)'(1);
        end else if (run_data_s && !addr_fire_s) begin
            outst_next_s = {1'b0, outst_r} - (CW+1)'(1);
        end else begin
            outst_next_s = {1'b0, outst_r};
        end
        if (addr_fire_s) begin
            word_cnt_next_s = word_cnt_r + CNT_WIDTH'(1);
        end else begin
            word_cnt_next_s = word_cnt_r;
        end
    end

    assign in_flight_next_s = {1'b0, fifo_cnt_next_s} + {1'b0, outst_next_s};
    assign addr_sum_s       = CNT_WIDTH'(base_r) + word_cnt_next_s;

    // Control FSM: start/ack in IDLE, streaming in RUN, level done until acknowledged.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_r     <= ST_IDLE;
            base_r      <= {ADDR_WIDTH{1'b0}};
            start_ack_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r     <= ST_RUN;
                        start_ack_r <= 1'b1;
                        base_r      <= frame_base(bus.frame_sel, F1_BASE_C);
                    end else begin
                        start_ack_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    start_ack_r <= 1'b0;
                    if (last_fire_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    start_ack_r <= 1'b0;
                    if (bus.done_ack) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    start_ack_r <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    // Read-address issue: one credit per free FIFO slot not already claimed by an outstanding read.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            word_cnt_r   <= {CNT_WIDTH{1'b0}};
            outst_r      <= {CW{1'b0}};
            addr_r       <= {ADDR_WIDTH{1'b0}};
            addr_valid_r <= 1'b0;
            data_ready_r <= 1'b1;
        end else if (start_go_s) begin
            word_cnt_r   <= {CNT_WIDTH{1'b0}};
            outst_r      <= {CW{1'b0}};
            addr_r       <= frame_base(bus.frame_sel, F1_BASE_C);
            addr_valid_r <= 1'b0;
            data_ready_r <= (fifo_cnt_next_s != (CW+1)'(FIFO_DEPTH));
        end else begin
            word_cnt_r   <= word_cnt_next_s;
            outst_r      <= outst_next_s[CW-1:0];
            addr_r       <= addr_sum_s[ADDR_WIDTH-1:0];
            addr_valid_r <= run_s && !last_fire_s && (word_cnt_next_s < WORDS_C) &&
                            (in_flight_next_s < (CW+2)'(FIFO_DEPTH));
            data_ready_r <= (fifo_cnt_next_s != (CW+1)'(FIFO_DEPTH));
        end
    end

    // Unpack shift register (byte 0 leaves first) and pixel counter.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            shift_r       <= 32'd0;
            byte_idx_r    <= 2'd0;
            unpack_full_r <= 1'b0;
            pix_cnt_r     <= {CNT_WIDTH{1'b0}};
            last_r        <= 1'b0;
        end else if (start_go_s) begin
            shift_r       <= 32'd0;
            byte_idx_r    <= 2'd0;
            unpack_full_r <= 1'b0;
            pix_cnt_r     <= {CNT_WIDTH{1'b0}};
            last_r        <= (LAST_PIX_C == {CNT_WIDTH{1'b0}});
        end else begin
            if (load_s) begin
                shift_r       <= load_word_s;
                byte_idx_r    <= 2'd0;
                unpack_full_r <= 1'b1;
            end else if (pixel_fire_s) begin
                shift_r       <= {8'd0, shift_r[31:8]};
                byte_idx_r    <= byte_idx_r + 2'd1;
                unpack_full_r <= (byte_idx_r != 2'd3);
            end
            if (pixel_fire_s) begin
                pix_cnt_r <= pix_cnt_r + CNT_WIDTH'(1);
                last_r    <= ((pix_cnt_r + CNT_WIDTH'(1)) == LAST_PIX_C);
            end
        end
    end

    assign bus.start_ack   = start_ack_r;
    assign bus.done        = done_r;
    assign bus.addr        = addr_r;
    assign bus.addr_valid  = addr_valid_r;
    assign bus.data_ready  = data_ready_r;
    assign bus.pixel       = shift_r[7:0];
    assign bus.pixel_valid = unpack_full_r;
    assign bus.pixel_last  = last_r && unpack_full_r;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Randomized bench for sram_frame_reader: 1-cycle arbiter model with random SRAM contents,
// expected pixels and addresses derived from frame base and little-endian byte order.
module tb_sram_frame_reader;
    import sram_frame_reader_pkg::*;

    localparam int NPIX  = 16;
    localparam int WORDS = NPIX / 4;
    localparam int DEPTH = 4;
    localparam int F1    = 100;

    logic clock   = 1'b0;
    logic reset_l = 1'b0;
    always #5 clock = ~clock;

    sram_frame_reader_if bus ();

    sram_frame_reader #(
        .N_PIXEL     (NPIX),
        .FRAME1_BASE (F1),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock   (clock),
        .reset_l (reset_l),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]           mem [256];
    logic [7:0]            exp_pix [NPIX];
    logic [ADDR_WIDTH-1:0] cur_base;
    logic [ADDR_WIDTH-1:0] rq [$];
    bit                    hold      = 1'b0;
    bit                    toggle_en = 1'b0;

    int pix_idx, addr_idx, ack_cnt, cyc, first_cyc, last_cyc;
    bit a_fire_n, d_fire_n, prev_stall, prev_done;
    logic [ADDR_WIDTH-1:0] a_addr_n;
    logic [7:0] prev_pix;
    logic       prev_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arbiter R1 model: accepts every address, returns mem[addr] one cycle later unless held.
    initial begin
        bus.data_valid  = 1'b0;
        bus.data        = 32'd0;
        bus.pixel_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (!reset_l) begin
                rq.delete();
            end else begin
                if (d_fire_n) void'(rq.pop_front());
                if (a_fire_n) rq.push_back(a_addr_n);
            end
            bus.data_valid  = !hold && (rq.size() > 0);
            bus.data        = (rq.size() > 0) ? mem[rq[0][7:0]] : 32'd0;
            bus.pixel_ready = toggle_en ? ~bus.pixel_ready : 1'b1;
        end
    end

    // Monitor: handshakes observed mid-cycle, compared to the frame model.
    always @(negedge clock) begin
        cyc++;
        a_fire_n = bus.addr_valid && bus.addr_ready;
        a_addr_n = bus.addr;
        d_fire_n = bus.data_valid && bus.data_ready;
        if (!reset_l) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (a_fire_n) begin
                if (addr_idx < WORDS) chk("addr", bus.addr, cur_base + addr_idx);
                else chk("extra_addr", addr_idx, WORDS - 1);
                addr_idx++;
            end
            if (prev_stall) begin
                chk("stall_valid", bus.pixel_valid, 1'b1);
                chk("stall_pixel", bus.pixel, prev_pix);
                chk("stall_last", bus.pixel_last, prev_last);
            end
            if (bus.pixel_valid && bus.pixel_ready) begin
                if (pix_idx < NPIX) begin
                    chk("pixel", bus.pixel, exp_pix[pix_idx]);
                    chk("pixel_last", bus.pixel_last, pix_idx == NPIX - 1);
                end else begin
                    chk("extra_pixel", pix_idx, NPIX - 1);
                end
                if (pix_idx == 0) first_cyc = cyc;
                last_cyc = cyc;
                pix_idx++;
            end
            prev_stall = bus.pixel_valid && !bus.pixel_ready;
            prev_pix   = bus.pixel;
            prev_last  = bus.pixel_last;
            if (bus.done && !prev_done) chk("done_after_full_frame", pix_idx, NPIX);
            prev_done = bus.done;
            if (bus.start_ack) ack_cnt++;
        end
    end

    task automatic begin_frame(input bit sel, input bit keep);
        bit seen = 1'b0;
        for (int i = 1; i < 256; i++) mem[i] = $urandom;
        cur_base = sel ? ADDR_WIDTH'(F1) : ADDR_WIDTH'(0);
        for (int w = 0; w < WORDS; w++)
            for (int k = 0; k < 4; k++)
                exp_pix[w*4+k] = mem[cur_base[7:0] + w][8*k +: 8];
        pix_idx       = 0;
        addr_idx      = 0;
        ack_cnt       = 0;
        bus.frame_sel = sel;
        bus.start     = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (bus.start_ack) seen = 1'b1;
        end
        chk("start_ack_seen", seen, 1'b1);
        if (seen) begin
            chk("addr_valid_at_ack", bus.addr_valid, 1'b0);
            @(posedge clock);
            #1;
            if (!keep) bus.start = 1'b0;
            @(negedge clock);
            chk("first_addr_valid", bus.addr_valid, 1'b1);
        end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (bus.done) seen = 1'b1;
        end
        chk("done_seen", seen, 1'b1);
    endtask

    task automatic finish_frame();
        chk("pixel_count", pix_idx, NPIX);
        chk("addr_count", addr_idx, WORDS);
        repeat (3) @(negedge clock);
        chk("done_held", bus.done, 1'b1);
        @(posedge clock);
        #1 bus.done_ack = 1'b1;
        @(posedge clock);
        #1 bus.done_ack = 1'b0;
        @(negedge clock);
        chk("done_dropped", bus.done, 1'b0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.frame_sel  = 1'b0;
        bus.done_ack   = 1'b0;
        bus.addr_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h04030201;

        repeat (3) @(negedge clock);
        chk("rst_start_ack", bus.start_ack, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_addr_valid", bus.addr_valid, 1'b0);
        chk("rst_data_ready", bus.data_ready, 1'b1);
        chk("rst_pixel", bus.pixel, 8'd0);
        chk("rst_pixel_valid", bus.pixel_valid, 1'b0);
        chk("rst_pixel_last", bus.pixel_last, 1'b0);
        @(posedge clock);
        #1 reset_l = 1'b1;
        repeat (2) @(negedge clock);

        // Frame 0, unstalled: no bubbles between first and last pixel.
        begin_frame(1'b0, 1'b0);
        chk("word0_pixel0", exp_pix[0], 8'h01);
        wait_done();
        chk("no_bubbles", last_cyc - first_cyc, NPIX - 1);
        finish_frame();

        // Frame 1 from FRAME1_BASE.
        begin_frame(1'b1, 1'b0);
        wait_done();
        finish_frame();

        // Arbiter withholds data: credits cap the outstanding reads.
        hold = 1'b1;
        begin_frame(1'b0, 1'b0);
        repeat (20) @(negedge clock);
        chk("hold_addr_count", addr_idx, DEPTH);
        chk("hold_addr_valid", bus.addr_valid, 1'b0);
        chk("hold_no_pixels", pix_idx, 0);
        hold = 1'b0;
        wait_done();
        finish_frame();

        // pixel_ready toggling every cycle.
        toggle_en = 1'b1;
        begin_frame(1'b1, 1'b0);
        wait_done();
        toggle_en = 1'b0;
        finish_frame();

        // Reset in the middle of a frame, then a full fresh frame.
        begin_frame(1'b0, 1'b0);
        for (int i = 0; i < 200 && pix_idx < 7; i++) @(negedge clock);
        chk("reached_pixel7", pix_idx >= 7, 1'b1);
        @(posedge clock);
        #1 reset_l = 1'b0;
        @(negedge clock);
        chk("mid_rst_pixel_valid", bus.pixel_valid, 1'b0);
        chk("mid_rst_addr_valid", bus.addr_valid, 1'b0);
        chk("mid_rst_data_ready", bus.data_ready, 1'b1);
        chk("mid_rst_done", bus.done, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1 reset_l = 1'b1;
        pix_idx = 0;
        repeat (10) @(negedge clock);
        chk("no_done_after_abort", bus.done, 1'b0);
        begin_frame(1'b0, 1'b0);
        wait_done();
        finish_frame();

        // start held through DONE: a second ack only after IDLE is re-entered.
        begin_frame(1'b1, 1'b1);
        wait_done();
        repeat (3) @(negedge clock);
        chk("no_reack_in_done", ack_cnt, 1);
        finish_frame();
        chk("no_reack_before_idle", ack_cnt, 1);
        begin_frame(1'b0, 1'b0);
        wait_done();
        finish_frame();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
